// File: rtl/gcd_fsmd_param_pkg.sv
// Shared definitions for the parametrised GCD engine: controller state
// encoding, datapath operation codes, reduction-mode constants and the
// width helper for the Stein power-of-two counter.
package gcd_fsmd_param_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CALC = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Operation requested from the datapath in the current cycle.
   typedef enum logic [2:0] {
      DP_HOLD     = 3'd0,
      DP_CAPTURE  = 3'd1,
      DP_RES_ZERO = 3'd2,
      DP_RES_EQ   = 3'd3,
      DP_STEP     = 3'd4
   } dp_op_t;

   localparam int MODE_EUCLID = 0;
   localparam int MODE_STEIN  = 1;

   // Bits needed to count common factors of two in a WIDTH-bit operand.
   function automatic int k_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/gcd_fsmd_param_if.sv
// Host-side handshake bundle of the GCD engine: start request with operands,
// and busy/done status with the held result, iteration count and zero flag.
interface gcd_fsmd_param_if #(
   parameter int WIDTH = 8
);
   logic             go_i;
   logic [WIDTH-1:0] x_i;
   logic [WIDTH-1:0] y_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] d_o;
   logic [WIDTH:0]   cycles_o;
   logic             zero_o;

   modport master (
      output go_i, x_i, y_i,
      input  busy_o, done_o, d_o, cycles_o, zero_o
   );

   modport slave (
      input  go_i, x_i, y_i,
      output busy_o, done_o, d_o, cycles_o, zero_o
   );
endinterface

// File: rtl/gcd_fsmd_param_datapath.sv
// GCD datapath: working operands x/y, the Stein shift count k and the result
// register d, plus the equality/ordering compare and zero detection the
// controller steers on. Subtraction is always larger-minus-smaller.
module gcd_fsmd_param_datapath
   import gcd_fsmd_param_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MODE  = MODE_EUCLID
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  dp_op_t           i_op,
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   output logic             o_eq,
   output logic             o_any_zero,
   output logic [WIDTH-1:0] o_d
);

   localparam int            KW    = k_width(WIDTH);
   localparam logic [KW-1:0] K_ONE = KW'(1);
   localparam bit            STEIN = (MODE == MODE_STEIN);

   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_d;
   logic [KW-1:0]    r_k;
   logic             w_lt;

   assign o_eq       = (r_x == r_y);
   assign w_lt       = (r_x < r_y);
   assign o_any_zero = (r_x == '0) || (r_y == '0);
   assign o_d        = r_d;

   // Operand capture, one reduction step per cycle, and result latch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x <= '0;
         r_y <= '0;
         r_k <= '0;
         r_d <= '0;
      end else begin
         case (i_op)
            DP_CAPTURE: begin
               r_x <= i_x;
               r_y <= i_y;
               r_k <= '0;
            end
            DP_RES_ZERO: r_d <= r_x | r_y;
            // k stays zero in Euclid mode, so the shift is a plain copy there.
            DP_RES_EQ:   r_d <= r_x << r_k;
            DP_STEP: begin
               if (STEIN && !r_x[0] && !r_y[0]) begin
                  r_x <= r_x >> 1;
                  r_y <= r_y >> 1;
                  r_k <= r_k + K_ONE;
               end else if (STEIN && !r_x[0]) begin
                  r_x <= r_x >> 1;
               end else if (STEIN && !r_y[0]) begin
                  r_y <= r_y >> 1;
               end else if (w_lt) begin
                  r_y <= r_y - r_x;
               end else begin
                  r_x <= r_x - r_y;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/gcd_fsmd_param.sv
// Parametrised GCD engine top: controller FSM (IDLE/LOAD/CALC/DONE) holding
// the state, the saturating CALC-cycle counter and the registered status
// outputs; the arithmetic lives in gcd_fsmd_param_datapath.
module gcd_fsmd_param
   import gcd_fsmd_param_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int MODE  = MODE_EUCLID
) (
   input  logic           CLK,
   input  logic           RESET,
   gcd_fsmd_param_if.slave bus
);

   localparam logic [WIDTH:0] CNT_ONE = (WIDTH+1)'(1);

   state_t           r_state;
   logic [WIDTH:0]   r_cnt;
   logic [WIDTH:0]   r_cycles;
   logic             r_busy;
   logic             r_done;
   logic             r_zero;

   dp_op_t           w_op;
   logic             w_eq;
   logic             w_any_zero;
   logic [WIDTH-1:0] w_d;
   logic [WIDTH:0]   w_cnt_inc;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   assign w_cnt_inc = sat_inc(r_cnt);

   // Datapath command decode from the current state and compare flags.
   always_comb begin
      w_op = DP_HOLD;
      case (r_state)
         ST_IDLE: if (bus.go_i) w_op = DP_CAPTURE;
         ST_LOAD: if (w_any_zero) w_op = DP_RES_ZERO;
         ST_CALC: w_op = w_eq ? DP_RES_EQ : DP_STEP;
         default: w_op = DP_HOLD;
      endcase
   end

   gcd_fsmd_param_datapath #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
   ) u_datapath (
      .i_clk      (CLK),
      .i_rst_n    (RESET),
      .i_op       (w_op),
      .i_x        (bus.x_i),
      .i_y        (bus.y_i),
      .o_eq       (w_eq),
      .o_any_zero (w_any_zero),
      .o_d        (w_d)
   );

   // Controller FSM with registered busy/done/zero/cycles outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_cycles <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.go_i) begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_any_zero) begin
                  r_zero   <= 1'b1;
                  r_cycles <= '0;
                  r_state  <= ST_DONE;
               end else begin
                  r_state  <= ST_CALC;
               end
            end
            ST_CALC: begin
               // The step that detects equality counts as a CALC cycle too.
               r_cnt <= w_cnt_inc;
               if (w_eq) begin
                  r_zero   <= 1'b0;
                  r_cycles <= w_cnt_inc;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy_o   = r_busy;
   assign bus.done_o   = r_done;
   assign bus.d_o      = w_d;
   assign bus.cycles_o = r_cycles;
   assign bus.zero_o   = r_zero;

endmodule

// File: tb/tb_gcd_fsmd_param.sv
// Directed bench for gcd_fsmd_param: Euclid and Stein 8-bit instances plus a
// 16-bit Euclid instance, sharing clock and reset.
module tb_gcd_fsmd_param;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   gcd_fsmd_param_if #(.WIDTH(8))  bus_e ();
   gcd_fsmd_param_if #(.WIDTH(8))  bus_s ();
   gcd_fsmd_param_if #(.WIDTH(16)) bus_w ();

   gcd_fsmd_param #(.WIDTH(8), .MODE(0)) u_e (
      .CLK(clk), .RESET(rst_n), .bus(bus_e.slave));
   gcd_fsmd_param #(.WIDTH(8), .MODE(1)) u_s (
      .CLK(clk), .RESET(rst_n), .bus(bus_s.slave));
   gcd_fsmd_param #(.WIDTH(16), .MODE(0)) u_w (
      .CLK(clk), .RESET(rst_n), .bus(bus_w.slave));

   // sel: 0 = Euclid W8, 1 = Stein W8, 2 = Euclid W16
   task automatic drive(input int sel, input logic go, input logic [15:0] x, input logic [15:0] y);
      case (sel)
         0: begin bus_e.go_i = go; bus_e.x_i = x[7:0]; bus_e.y_i = y[7:0]; end
         1: begin bus_s.go_i = go; bus_s.x_i = x[7:0]; bus_s.y_i = y[7:0]; end
         default: begin bus_w.go_i = go; bus_w.x_i = x; bus_w.y_i = y; end
      endcase
   endtask

   function automatic logic get_done(input int sel);
      return (sel == 0) ? bus_e.done_o : (sel == 1) ? bus_s.done_o : bus_w.done_o;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? bus_e.busy_o : (sel == 1) ? bus_s.busy_o : bus_w.busy_o;
   endfunction

   function automatic logic get_zero(input int sel);
      return (sel == 0) ? bus_e.zero_o : (sel == 1) ? bus_s.zero_o : bus_w.zero_o;
   endfunction

   function automatic logic [15:0] get_d(input int sel);
      return (sel == 0) ? {8'h00, bus_e.d_o} : (sel == 1) ? {8'h00, bus_s.d_o} : bus_w.d_o;
   endfunction

   function automatic logic [16:0] get_cyc(input int sel);
      return (sel == 0) ? {8'h00, bus_e.cycles_o} : (sel == 1) ? {8'h00, bus_s.cycles_o} : bus_w.cycles_o;
   endfunction

   // Issue one go pulse and count edges from accept to done_o (-1 on timeout).
   task automatic run_op(input int sel, input logic [15:0] x, input logic [15:0] y,
                         input int limit, output int lat);
      @(negedge clk);
      drive(sel, 1'b1, x, y);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, x, y);
      lat = 0;
      while (!get_done(sel) && lat < limit) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!get_done(sel)) lat = -1;
   endtask

   task automatic test_reset;
      for (int s = 0; s < 3; s++) begin
         total++;
         if ({get_d(s), get_cyc(s), get_zero(s), get_busy(s), get_done(s)} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs dut=%0d actual d=%0d cyc=%0d zero=%b busy=%b done=%b required all 0",
                     s, get_d(s), get_cyc(s), get_zero(s), get_busy(s), get_done(s));
         end
      end
   endtask

   task automatic test_euclid;
      int lat;
      run_op(0, 16'd12, 16'd18, 50, lat);
      total++;
      if (lat !== 5) begin bad++; $display("FAIL euclid_latency actual=%0d required=5", lat); end
      total++;
      if (get_d(0) !== 16'd6) begin bad++; $display("FAIL euclid_d actual=%0d required=6", get_d(0)); end
      total++;
      if (get_cyc(0) !== 17'd3) begin bad++; $display("FAIL euclid_cycles actual=%0d required=3", get_cyc(0)); end
      total++;
      if (get_zero(0) !== 1'b0) begin bad++; $display("FAIL euclid_zero actual=%b required=0", get_zero(0)); end
      @(posedge clk);
      #1;
      total++;
      if (get_done(0) !== 1'b0) begin bad++; $display("FAIL euclid_done_width actual=%b required=0", get_done(0)); end
      total++;
      if (get_d(0) !== 16'd6) begin bad++; $display("FAIL euclid_d_held actual=%0d required=6", get_d(0)); end
   endtask

   task automatic test_stein;
      int lat;
      run_op(1, 16'd12, 16'd18, 50, lat);
      total++;
      if (lat !== 7) begin bad++; $display("FAIL stein_latency actual=%0d required=7", lat); end
      total++;
      if (get_d(1) !== 16'd6) begin bad++; $display("FAIL stein_d_12_18 actual=%0d required=6", get_d(1)); end
      total++;
      if (get_cyc(1) !== 17'd5) begin bad++; $display("FAIL stein_cycles_12_18 actual=%0d required=5", get_cyc(1)); end
      run_op(1, 16'd48, 16'd180, 100, lat);
      total++;
      if (get_d(1) !== 16'd12) begin bad++; $display("FAIL stein_d_48_180 actual=%0d required=12", get_d(1)); end
      run_op(1, 16'd255, 16'd255, 50, lat);
      total++;
      if (get_d(1) !== 16'd255) begin bad++; $display("FAIL stein_d_255 actual=%0d required=255", get_d(1)); end
      total++;
      if (get_cyc(1) !== 17'd1) begin bad++; $display("FAIL stein_cycles_255 actual=%0d required=1", get_cyc(1)); end
   endtask

   task automatic test_zero;
      int lat;
      run_op(0, 16'd0, 16'd9, 20, lat);
      total++;
      if (lat !== 2) begin bad++; $display("FAIL zero_latency_0_9 actual=%0d required=2", lat); end
      total++;
      if ({get_d(0), get_zero(0), get_cyc(0)} !== {16'd9, 1'b1, 17'd0}) begin
         bad++;
         $display("FAIL zero_0_9 actual d=%0d zero=%b cyc=%0d required d=9 zero=1 cyc=0",
                  get_d(0), get_zero(0), get_cyc(0));
      end
      run_op(0, 16'd0, 16'd0, 20, lat);
      total++;
      if (lat !== 2) begin bad++; $display("FAIL zero_latency_0_0 actual=%0d required=2", lat); end
      total++;
      if ({get_d(0), get_zero(0)} !== {16'd0, 1'b1}) begin
         bad++;
         $display("FAIL zero_0_0 actual d=%0d zero=%b required d=0 zero=1", get_d(0), get_zero(0));
      end
      run_op(1, 16'd9, 16'd0, 20, lat);
      total++;
      if ({get_d(1), get_zero(1), lat} !== {16'd9, 1'b1, 32'd2}) begin
         bad++;
         $display("FAIL zero_stein_9_0 actual d=%0d zero=%b lat=%0d required d=9 zero=1 lat=2",
                  get_d(1), get_zero(1), lat);
      end
   endtask

   task automatic test_worst_case;
      int lat;
      run_op(0, 16'd1, 16'd255, 400, lat);
      total++;
      if ({get_d(0), get_cyc(0)} !== {16'd1, 17'd255}) begin
         bad++;
         $display("FAIL worst_w8 actual d=%0d cyc=%0d required d=1 cyc=255", get_d(0), get_cyc(0));
      end
      total++;
      if (lat !== 257) begin bad++; $display("FAIL worst_w8_latency actual=%0d required=257", lat); end
      run_op(2, 16'd1, 16'd65535, 70000, lat);
      total++;
      if ({get_d(2), get_cyc(2)} !== {16'd1, 17'd65535}) begin
         bad++;
         $display("FAIL worst_w16 actual d=%0d cyc=%0d required d=1 cyc=65535", get_d(2), get_cyc(2));
      end
      total++;
      if (get_zero(2) !== 1'b0) begin bad++; $display("FAIL worst_w16_zero actual=%b required=0", get_zero(2)); end
   endtask

   task automatic test_reset_mid;
      int lat;
      int seen;
      @(negedge clk);
      drive(0, 1'b1, 16'd1, 16'd255);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 16'd1, 16'd255);
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({get_d(0), get_cyc(0), get_zero(0), get_busy(0), get_done(0)} !== 36'd0) begin
         bad++;
         $display("FAIL reset_mid_async actual d=%0d cyc=%0d zero=%b busy=%b done=%b required all 0",
                  get_d(0), get_cyc(0), get_zero(0), get_busy(0), get_done(0));
      end
      seen = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (get_done(0)) seen++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (get_done(0) || get_busy(0)) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL reset_mid_no_done actual=%0d activity cycles required=0", seen); end
      run_op(0, 16'd7, 16'd21, 50, lat);
      total++;
      if ({get_d(0), get_cyc(0), lat} !== {16'd7, 17'd3, 32'd5}) begin
         bad++;
         $display("FAIL reset_mid_next_op actual d=%0d cyc=%0d lat=%0d required d=7 cyc=3 lat=5",
                  get_d(0), get_cyc(0), lat);
      end
   endtask

   task automatic test_back_to_back;
      int acc;
      int ndone;
      logic nxt;
      int de[3];
      logic [15:0] dd[3];
      int exp_e[3];
      logic [15:0] exp_d[3];
      exp_e = '{5, 12, 18};
      exp_d = '{16'd6, 16'd7, 16'd3};
      de = '{-1, -1, -1};
      dd = '{16'd0, 16'd0, 16'd0};
      @(negedge clk);
      drive(0, 1'b1, 16'd12, 16'd18);
      @(posedge clk);
      #1;
      drive(0, 1'b1, 16'd35, 16'd14);
      acc = 1;
      nxt = 1'b0;
      ndone = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (nxt) begin
            nxt = 1'b0;
            acc++;
            if (acc == 2) drive(0, 1'b1, 16'd9, 16'd6);
            else drive(0, 1'b0, 16'hAA, 16'h55);
         end
         if (get_done(0)) begin
            if (ndone < 3) begin
               de[ndone] = e;
               dd[ndone] = get_d(0);
            end
            ndone++;
            nxt = 1'b1;
         end
      end
      total++;
      if (ndone !== 3) begin bad++; $display("FAIL b2b_pulse_count actual=%0d required=3", ndone); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({de[i], dd[i]} !== {exp_e[i], exp_d[i]}) begin
            bad++;
            $display("FAIL b2b_op%0d actual edge=%0d d=%0d required edge=%0d d=%0d",
                     i, de[i], dd[i], exp_e[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_busy_ignore;
      int ndone;
      int dedge;
      logic [15:0] dval;
      logic [16:0] cval;
      ndone = 0;
      dedge = -1;
      dval = '0;
      cval = '0;
      @(negedge clk);
      drive(0, 1'b1, 16'd12, 16'd18);
      @(posedge clk);
      #1;
      drive(0, 1'b1, 16'd1, 16'd1);
      total++;
      if (get_busy(0) !== 1'b1) begin bad++; $display("FAIL busy_after_accept actual=%b required=1", get_busy(0)); end
      for (int e = 1; e <= 15; e++) begin
         @(posedge clk);
         #1;
         if (e <= 3) drive(0, (e % 2) == 1, 16'd1, 16'd1);
         else drive(0, 1'b0, 16'd1, 16'd1);
         if (e == 4) begin
            total++;
            if (get_busy(0) !== 1'b1) begin bad++; $display("FAIL busy_in_done_state actual=%b required=1", get_busy(0)); end
         end
         if (get_done(0)) begin
            ndone++;
            dedge = e;
            dval = get_d(0);
            cval = get_cyc(0);
         end
      end
      total++;
      if ({ndone, dedge} !== {32'd1, 32'd5}) begin
         bad++;
         $display("FAIL busy_ignore_pulses actual count=%0d edge=%0d required count=1 edge=5", ndone, dedge);
      end
      total++;
      if ({dval, cval} !== {16'd6, 17'd3}) begin
         bad++;
         $display("FAIL busy_ignore_result actual d=%0d cyc=%0d required d=6 cyc=3", dval, cval);
      end
      total++;
      if (get_busy(0) !== 1'b0) begin bad++; $display("FAIL busy_after_done actual=%b required=0", get_busy(0)); end
   endtask

   initial begin
      drive(0, 1'b0, 16'd0, 16'd0);
      drive(1, 1'b0, 16'd0, 16'd0);
      drive(2, 1'b0, 16'd0, 16'd0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      @(negedge clk);
      rst_n = 1'b1;
      test_euclid;
      test_stein;
      test_zero;
      test_worst_case;
      test_reset_mid;
      test_back_to_back;
      test_busy_ignore;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
